// File: rtl/aes_encrypt_core_if.sv
// Handshake bundle for aes_encrypt_core: plaintext/key offered in, ciphertext offered out.
interface aes_encrypt_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  modport master (output in_valid, in_block, in_key, out_ready,
                  input  in_ready, out_valid, out_block);
  modport slave  (input  in_valid, in_block, in_key, out_ready,
                  output in_ready, out_valid, out_block);
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per cycle, round keys supplied by an external
// key-expansion stage that is steered through ke_en/ke_round.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv_s;

  assign inv_s    = gf_inv(in_byte);
  assign out_byte = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]} ^
                    {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
endmodule

module aes_encrypt_core (
  input  logic               clk,
  input  logic               rst_n,
  aes_encrypt_core_if.slave  bus,
  output logic               ke_en,
  output logic [3:0]         ke_round,
  output logic [127:0]       ke_cipher_key,
  input  logic [127:0]       round_key
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] sb_s, sr_s, mc_s, round_s;
  logic         in_ready_s, hs_s, last_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte g sits at row g%4, column g/4; ShiftRows pulls row r from column (c+r)%4.
  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_sub
      localparam int R = g % 4;
      localparam int C = g / 4;
      aes_sbox u_sbox (.in_byte(st_q[127-8*g -: 8]), .out_byte(sb_s[127-8*g -: 8]));
      assign sr_s[127-8*g -: 8] = sb_s[127-8*(R + 4*((C + R) % 4)) -: 8];
    end
    for (g = 0; g < 4; g++) begin : g_mix
      assign mc_s[127-32*g -: 32] = mix_col(sr_s[127-32*g -: 32]);
    end
  endgenerate

  assign last_s        = (rnd_q == 4'd10);
  assign round_s       = (last_s ? sr_s : mc_s) ^ round_key;
  assign in_ready_s    = rst_n & (fsm_q == IDLE);
  assign hs_s          = bus.in_valid & in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_block = (fsm_q == DONE) ? st_q : 128'd0;
  assign ke_cipher_key = bus.in_key;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
      st_q  <= 128'd0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
    end
  end

  // Next-state, round datapath selection and key-expansion steering.
  always_comb begin
    fsm_d    = fsm_q;
    rnd_d    = rnd_q;
    st_d     = st_q;
    ke_en    = 1'b0;
    ke_round = 4'd0;
    case (fsm_q)
      IDLE: begin
        if (hs_s) begin
          st_d  = bus.in_block ^ bus.in_key;
          ke_en = 1'b1;
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end else begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        st_d = round_s;
        if (last_s) begin
          rnd_d = 4'd0;
          fsm_d = DONE;
        end else begin
          ke_en    = 1'b1;
          ke_round = rnd_q;
          rnd_d    = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end else begin
          fsm_d = DONE;
        end
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = 4'd0;
        st_d  = 128'd0;
      end
    endcase
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core with a behavioural key-expansion stage built from a
// table S-box; checks FIPS-197 vectors, latency, throughput, backpressure and reset.
module tb_aes_encrypt_core;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ke_en;
  logic [3:0]   ke_round;
  logic [127:0] ke_cipher_key;
  logic [127:0] round_key = 128'd0;
  int           total = 0;
  int           bad = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_encrypt_core_if bus ();

  aes_encrypt_core dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ke_en(ke_en), .ke_round(ke_round),
    .ke_cipher_key(ke_cipher_key), .round_key(round_key));

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    int idx;
    row = sbox_rows[b[7:4]];
    idx = (15 - int'(b[3:0])) * 8;
    return row[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;  4'd4: return 8'h08;
      4'd5: return 8'h10;  4'd6: return 8'h20;  4'd7: return 8'h40;  4'd8: return 8'h80;
      4'd9: return 8'h1b;  4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon(i), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Key-expansion stage: ke_en with ke_round = r registers K(r+1).
  always @(posedge clk) begin
    if (ke_en) round_key <= expand((ke_round == 4'd0) ? ke_cipher_key : round_key, ke_round + 4'd1);
  end

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk_w(tag, {127'd0, obs}, {127'd0, exp});
  endtask

  task automatic chk_n(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    chk_w(tag, {124'd0, obs}, {124'd0, exp});
  endtask

  task automatic handshake(input logic [127:0] key, input logic [127:0] pt);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    bus.in_block = pt;
    #1;
    chk_b("hs_in_ready", bus.in_ready, 1'b1);
    chk_b("hs_ke_en", ke_en, 1'b1);
    chk_n("hs_ke_round", ke_round, 4'd0);
    chk_w("hs_ke_cipher_key", ke_cipher_key, key);
  endtask

  task automatic rounds(input logic busy, input logic valid_all, input logic [127:0] junk);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      bus.in_valid = valid_all | (busy & ((r == 3) || (r == 4)));
      bus.in_block = junk;
      bus.in_key   = ~junk;
      #1;
      chk_b("round_ke_en", ke_en, (r < 10));
      chk_n("round_ke_round", ke_round, (r < 10) ? 4'(r) : 4'd0);
      chk_b("round_in_ready", bus.in_ready, 1'b0);
      chk_b("round_out_valid", bus.out_valid, 1'b0);
      chk_w("round_out_block", bus.out_block, 128'd0);
    end
  endtask

  task automatic result(input logic [127:0] exp, input int stall, input logic hold_valid);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      bus.in_valid  = hold_valid;
      bus.out_ready = (i == stall);
      #1;
      chk_b("done_out_valid", bus.out_valid, 1'b1);
      chk_w("done_out_block", bus.out_block, exp);
      chk_b("done_in_ready", bus.in_ready, 1'b0);
      chk_b("done_ke_en", ke_en, 1'b0);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk_b({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk_b({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk_w({tag, "_out_block"}, bus.out_block, 128'd0);
    chk_b({tag, "_ke_en"}, ke_en, 1'b0);
    chk_n({tag, "_ke_round"}, ke_round, 4'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_block  = 128'd0;
    bus.in_key    = 128'd0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_b("in_reset_in_ready", bus.in_ready, 1'b0);
    chk_b("in_reset_ke_en", ke_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    #1;
    chk_b("reset_in_ready", bus.in_ready, 1'b1);
    chk_b("reset_out_valid", bus.out_valid, 1'b0);
    chk_b("reset_ke_en", ke_en, 1'b0);
    chk_n("reset_ke_round", ke_round, 4'd0);
    chk_w("reset_out_block", bus.out_block, 128'd0);

    // App. B with in_valid held high, straight into App. C one block per 12 cycles.
    handshake(KEY_B, PT_B);
    rounds(1'b0, 1'b1, 128'hdeadbeef_cafef00d_01234567_89abcdef);
    result(CT_B, 0, 1'b1);
    handshake(KEY_C, PT_C);
    rounds(1'b1, 1'b0, 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a);
    result(CT_C, 20, 1'b0);
    idle_check("after_stall");

    // Reset during round 5 drops the block without a later out_valid.
    handshake(KEY_C, PT_C);
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_b("midrst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_b("post_rst_in_ready", bus.in_ready, 1'b1);
    chk_b("post_rst_out_valid", bus.out_valid, 1'b0);
    chk_b("post_rst_ke_en", ke_en, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk_b("post_rst_no_out_valid", bus.out_valid, 1'b0);
    end
    handshake(KEY_B, PT_B);
    rounds(1'b0, 1'b0, 128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0);
    result(CT_B, 0, 1'b0);
    idle_check("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
